// File: rtl/bus_sram_slave.sv
// Burst-bus responder fronting an on-chip SRAM window: byte-enabled write bursts,
// pipelined read bursts, end/error signalling; all outputs are 0 when not driving.
module bus_sram_slave #(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int unsigned ADDR_BITS    = 10,
    parameter int unsigned WAIT_STATES  = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic [31:0] addressDataIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic [7:0]  burstSizeIn,
    input  logic        readNotWriteIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busErrorOut,
    output logic        busyOut
);

    localparam int unsigned DEPTH        = 1 << ADDR_BITS;
    localparam int unsigned TAG_LSB      = ADDR_BITS + 2;
    localparam int unsigned SUM_W        = ((ADDR_BITS > 8) ? ADDR_BITS : 8) + 1;
    localparam int unsigned LEFT_W       = 9;
    localparam int unsigned WAIT_W       = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int unsigned WR_BUSY_LAST = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        RD_END,
        WR_DATA,
        WR_BUSY,
        ERR,
        ERR_DRAIN
    } state_t;

    state_t                state, state_d;
    logic [ADDR_BITS-1:0]  word_addr, word_addr_d;
    logic [LEFT_W-1:0]     words_left, words_left_d;
    logic [3:0]            be_q, be_d;
    logic                  rnw_q, rnw_d;
    logic [WAIT_W-1:0]     wait_cnt, wait_cnt_d;

    logic [31:0]           data_d;
    logic                  valid_d, end_d, err_d, busy_d;

    logic [31:0]           mem [DEPTH];
    logic                  mem_we_c;
    logic [31:0]           rdata_c;

    logic                  sel_c;
    logic [ADDR_BITS-1:0]  begin_word_c;
    logic [SUM_W-1:0]      burst_end_c;
    logic                  begin_err_c;

    // Window decode and burst range check, evaluated on the begin cycle
    always_comb begin
        sel_c        = beginTransactionIn &&
                       (addressDataIn[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB]);
        begin_word_c = addressDataIn[TAG_LSB-1:2];
        burst_end_c  = SUM_W'(begin_word_c) + SUM_W'(burstSizeIn);
        begin_err_c  = (addressDataIn[1:0] != 2'b00) || (burst_end_c > SUM_W'(DEPTH - 1));
    end

    assign rdata_c = mem[word_addr];

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d      = state;
        word_addr_d  = word_addr;
        words_left_d = words_left;
        be_d         = be_q;
        rnw_d        = rnw_q;
        wait_cnt_d   = wait_cnt;
        data_d       = '0;
        valid_d      = 1'b0;
        end_d        = 1'b0;
        err_d        = 1'b0;
        busy_d       = 1'b0;
        mem_we_c     = 1'b0;

        case (state)
            IDLE: begin
                if (sel_c) begin
                    word_addr_d  = begin_word_c;
                    words_left_d = LEFT_W'(burstSizeIn) + LEFT_W'(1);
                    be_d         = byteEnablesIn;
                    rnw_d        = readNotWriteIn;
                    wait_cnt_d   = '0;
                    if (begin_err_c) begin
                        state_d = ERR;
                    end else if (readNotWriteIn) begin
                        state_d = RD_WAIT;
                    end else begin
                        state_d = WR_DATA;
                    end
                end
            end

            RD_WAIT: begin
                if (wait_cnt == WAIT_W'(WAIT_STATES)) begin
                    state_d = RD_DATA;
                end else begin
                    wait_cnt_d = wait_cnt + WAIT_W'(1);
                end
            end

            RD_DATA: begin
                data_d       = rdata_c;
                valid_d      = 1'b1;
                word_addr_d  = word_addr + ADDR_BITS'(1);
                words_left_d = words_left - LEFT_W'(1);
                if (words_left == LEFT_W'(1)) begin
                    state_d = RD_END;
                end
            end

            RD_END: begin
                end_d   = 1'b1;
                state_d = IDLE;
            end

            WR_DATA: begin
                // Words past the announced burst length are silently dropped
                if (dataValidIn && (words_left != '0)) begin
                    mem_we_c     = 1'b1;
                    word_addr_d  = word_addr + ADDR_BITS'(1);
                    words_left_d = words_left - LEFT_W'(1);
                    if (WAIT_STATES != 0) begin
                        busy_d     = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = WR_BUSY;
                    end
                end
                if (endTransactionIn) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            WR_BUSY: begin
                busy_d = 1'b1;
                if (wait_cnt == WAIT_W'(WR_BUSY_LAST)) begin
                    busy_d  = 1'b0;
                    state_d = WR_DATA;
                end else begin
                    wait_cnt_d = wait_cnt + WAIT_W'(1);
                end
                if (endTransactionIn) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            ERR: begin
                err_d   = 1'b1;
                end_d   = 1'b1;
                state_d = (rnw_q || endTransactionIn) ? IDLE : ERR_DRAIN;
            end

            ERR_DRAIN: begin
                if (endTransactionIn) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= IDLE;
            word_addr         <= '0;
            words_left        <= '0;
            be_q              <= '0;
            rnw_q             <= 1'b0;
            wait_cnt          <= '0;
            addressDataOut    <= '0;
            dataValidOut      <= 1'b0;
            endTransactionOut <= 1'b0;
            busErrorOut       <= 1'b0;
            busyOut           <= 1'b0;
        end else begin
            state             <= state_d;
            word_addr         <= word_addr_d;
            words_left        <= words_left_d;
            be_q              <= be_d;
            rnw_q             <= rnw_d;
            wait_cnt          <= wait_cnt_d;
            addressDataOut    <= data_d;
            dataValidOut      <= valid_d;
            endTransactionOut <= end_d;
            busErrorOut       <= err_d;
            busyOut           <= busy_d;
        end
    end

    // SRAM array: not reset, byte lanes written in bus byte order
    always_ff @(posedge clock) begin
        if (mem_we_c && reset) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[word_addr][8*b +: 8] <= addressDataIn[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_sram_slave.sv
// Directed bench: two responders share one wired-OR bus (zero and two wait states),
// driven by a transaction table plus hand sequences for reset and decode corners.
module tb_bus_sram_slave;

    logic        clock = 1'b0;
    logic        reset;
    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic [3:0]  byteEnablesIn;
    logic [7:0]  burstSizeIn;
    logic        readNotWriteIn;
    logic        dataValidIn;
    logic        endTransactionIn;

    logic [31:0] a_data, b_data;
    logic        a_valid, b_valid, a_end, b_end, a_err, b_err, a_busy, b_busy;

    logic [31:0] bus_data;
    logic        bus_valid, bus_end, bus_err, bus_busy;

    assign bus_data  = a_data | b_data;
    assign bus_valid = a_valid | b_valid;
    assign bus_end   = a_end | b_end;
    assign bus_err   = a_err | b_err;
    assign bus_busy  = a_busy | b_busy;

    always #5 clock = ~clock;

    bus_sram_slave #(.BASE_ADDRESS(32'h5000_0000), .ADDR_BITS(10), .WAIT_STATES(0)) dut (
        .clock(clock), .reset(reset),
        .beginTransactionIn(beginTransactionIn), .addressDataIn(addressDataIn),
        .byteEnablesIn(byteEnablesIn), .burstSizeIn(burstSizeIn),
        .readNotWriteIn(readNotWriteIn), .dataValidIn(dataValidIn),
        .endTransactionIn(endTransactionIn),
        .addressDataOut(a_data), .dataValidOut(a_valid), .endTransactionOut(a_end),
        .busErrorOut(a_err), .busyOut(a_busy)
    );

    bus_sram_slave #(.BASE_ADDRESS(32'h6000_0000), .ADDR_BITS(10), .WAIT_STATES(2)) dut_ws (
        .clock(clock), .reset(reset),
        .beginTransactionIn(beginTransactionIn), .addressDataIn(addressDataIn),
        .byteEnablesIn(byteEnablesIn), .burstSizeIn(burstSizeIn),
        .readNotWriteIn(readNotWriteIn), .dataValidIn(dataValidIn),
        .endTransactionIn(endTransactionIn),
        .addressDataOut(b_data), .dataValidOut(b_valid), .endTransactionOut(b_end),
        .busErrorOut(b_err), .busyOut(b_busy)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit              rnw;
        logic [31:0]     addr;
        logic [7:0]      burst;
        logic [3:0]      be;
        int              n;      // words sent (write) or expected (read)
        logic [3:0][31:0] d;
        bit              err;
        int              busy;   // busy cycles expected after each write word
        int              lat;    // edges from begin to first read word
    } row_t;

    function automatic row_t mk(input bit rnw, input logic [31:0] addr, input logic [7:0] burst,
                                input logic [3:0] be, input int n,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input bit err, input int busy, input int lat);
        row_t r;
        r.rnw = rnw; r.addr = addr; r.burst = burst; r.be = be; r.n = n;
        r.d[0] = d0; r.d[1] = d1; r.d[2] = d2; r.d[3] = d3;
        r.err = err; r.busy = busy; r.lat = lat;
        return r;
    endfunction

    task automatic do_write(input row_t r, input int idx);
        int cnt;
        int err_n;
        int end_n;
        int busy_n;
        @(negedge clock);
        beginTransactionIn = 1'b1; addressDataIn = r.addr; byteEnablesIn = r.be;
        burstSizeIn = r.burst; readNotWriteIn = 1'b0;
        @(negedge clock);
        beginTransactionIn = 1'b0; byteEnablesIn = '0; burstSizeIn = '0;
        if (r.err) begin
            err_n = 0; end_n = 0; busy_n = 0;
            dataValidIn = 1'b1; addressDataIn = 32'hBAD0_0BAD;
            for (int s = 0; s < 6; s++) begin
                err_n  += int'(bus_err);
                end_n  += int'(bus_end);
                busy_n += int'(bus_busy);
                @(negedge clock);
            end
            dataValidIn = 1'b0; endTransactionIn = 1'b1;
            @(negedge clock);
            endTransactionIn = 1'b0; addressDataIn = '0;
            check($sformatf("row%0d wr error pulses", idx), 32'(err_n), 32'd1);
            check($sformatf("row%0d wr end pulses", idx), 32'(end_n), 32'd1);
            check($sformatf("row%0d wr error busy", idx), 32'(busy_n), 32'd0);
        end else begin
            for (int i = 0; i < r.n; i++) begin
                addressDataIn = r.d[i]; dataValidIn = 1'b1;
                @(negedge clock);
                cnt = 0;
                while (bus_busy && cnt < 10) begin
                    cnt++;
                    @(negedge clock);
                end
                check($sformatf("row%0d busy after word%0d", idx, i), 32'(cnt), 32'(r.busy));
            end
            dataValidIn = 1'b0; addressDataIn = '0; endTransactionIn = 1'b1;
            @(negedge clock);
            endTransactionIn = 1'b0;
        end
    endtask

    task automatic do_read(input row_t r, input int idx);
        int got;
        int first;
        int last;
        int end_s;
        int end_n;
        int err_n;
        int busy_n;
        int stray;
        got = 0; first = -1; last = -1; end_s = -1; end_n = 0; err_n = 0; busy_n = 0; stray = 0;
        @(negedge clock);
        beginTransactionIn = 1'b1; addressDataIn = r.addr; byteEnablesIn = 4'hF;
        burstSizeIn = r.burst; readNotWriteIn = 1'b1;
        @(negedge clock);
        beginTransactionIn = 1'b0; addressDataIn = '0; byteEnablesIn = '0;
        burstSizeIn = '0; readNotWriteIn = 1'b0;
        for (int s = 1; s <= 40; s++) begin
            if (bus_valid) begin
                if (got < r.n && got < 4)
                    check($sformatf("row%0d read data%0d", idx, got), bus_data, r.d[got]);
                if (first < 0) first = s - 1;
                last = s - 1;
                got++;
            end else if (bus_data != '0) begin
                stray++;
            end
            if (bus_end) begin
                end_n++;
                if (end_s < 0) end_s = s - 1;
            end
            err_n  += int'(bus_err);
            busy_n += int'(bus_busy);
            if (end_s >= 0 && s - 1 > end_s) break;
            @(negedge clock);
        end
        check($sformatf("row%0d read word count", idx), 32'(got), 32'(r.n));
        check($sformatf("row%0d read end pulses", idx), 32'(end_n), 32'd1);
        check($sformatf("row%0d read error pulses", idx), 32'(err_n), r.err ? 32'd1 : 32'd0);
        check($sformatf("row%0d read busy", idx), 32'(busy_n), 32'd0);
        check($sformatf("row%0d idle data nonzero", idx), 32'(stray), 32'd0);
        if (r.n > 0) begin
            check($sformatf("row%0d first latency", idx), 32'(first), 32'(r.lat));
            check($sformatf("row%0d end after last", idx), 32'(end_s), 32'(last + 1));
        end
    endtask

    task automatic run_row(input row_t r, input int idx);
        if (r.rnw) do_read(r, idx);
        else       do_write(r, idx);
    endtask

    row_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] acc;
        int          wait_n;

        //            rnw  addr           burst  be    n  d0            d1           d2     d3     err busy lat
        tbl.push_back(mk(0, 32'h5000_0010, 8'd3, 4'hF, 4, 32'd1,        32'd2,       32'd3, 32'd4, 0, 0, 0));
        tbl.push_back(mk(1, 32'h5000_0010, 8'd3, 4'hF, 4, 32'd1,        32'd2,       32'd3, 32'd4, 0, 0, 2));
        tbl.push_back(mk(0, 32'h5000_0020, 8'd0, 4'hF, 1, 32'h11223344, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h5000_0020, 8'd0, 4'h3, 1, 32'hAABBCCDD, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h5000_0020, 8'd0, 4'hF, 1, 32'h1122CCDD, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 32'h5000_0FFC, 8'd1, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 32'h5000_0FFC, 8'd0, 4'hF, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h5000_0FFC, 8'd0, 4'hF, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 32'h5000_0012, 8'd0, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 32'h5000_0FF8, 8'd0, 4'hF, 1, 32'h12345678, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h5000_0FF8, 8'd2, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h5000_0FF8, 8'd0, 4'hF, 1, 32'h12345678, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 32'h5000_0010, 8'd0, 4'hC, 1, 32'hDEAD0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h5000_0010, 8'd1, 4'hF, 2, 32'hDEAD0001, 32'd2, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 32'h5000_0040, 8'd3, 4'hF, 2, 32'h0000000A, 32'h0000000B, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h5000_0040, 8'd1, 4'hF, 2, 32'h0000000A, 32'h0000000B, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 32'h5000_0054, 8'd0, 4'hF, 1, 32'h77, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h5000_0050, 8'd0, 4'hF, 2, 32'h55, 32'h66, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h5000_0050, 8'd1, 4'hF, 2, 32'h55, 32'h77, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 32'h6000_0000, 8'd2, 4'hF, 3, 32'h10, 32'h20, 32'h30, 0, 0, 2, 0));
        tbl.push_back(mk(1, 32'h6000_0000, 8'd2, 4'hF, 3, 32'h10, 32'h20, 32'h30, 0, 0, 0, 4));

        reset = 1'b0; beginTransactionIn = 1'b0; addressDataIn = '0; byteEnablesIn = '0;
        burstSizeIn = '0; readNotWriteIn = 1'b0; dataValidIn = 1'b0; endTransactionIn = 1'b0;
        repeat (3) @(negedge clock);
        check("reset outputs", {bus_data[31:4], bus_valid, bus_end, bus_err, bus_busy}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

        // Begin just below the window must be ignored by both responders
        @(negedge clock);
        beginTransactionIn = 1'b1; addressDataIn = 32'h4FFF_FFFC; byteEnablesIn = 4'hF;
        burstSizeIn = 8'd0; readNotWriteIn = 1'b1;
        @(negedge clock);
        beginTransactionIn = 1'b0; addressDataIn = '0; readNotWriteIn = 1'b0;
        acc = '0;
        for (int s = 0; s < 8; s++) begin
            acc = acc | bus_data | {28'd0, bus_valid, bus_end, bus_err, bus_busy};
            @(negedge clock);
        end
        check("unselected begin outputs", acc, 32'd0);

        // Reset asserted in the middle of a read burst
        beginTransactionIn = 1'b1; addressDataIn = 32'h5000_0010; byteEnablesIn = 4'hF;
        burstSizeIn = 8'd3; readNotWriteIn = 1'b1;
        @(negedge clock);
        beginTransactionIn = 1'b0; addressDataIn = '0; readNotWriteIn = 1'b0; burstSizeIn = '0;
        wait_n = 0;
        while (!bus_valid && wait_n < 10) begin
            wait_n++;
            @(negedge clock);
        end
        check("mid-read valid seen", 32'(bus_valid), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        check("reset mid-read outputs", bus_data | {28'd0, bus_valid, bus_end, bus_err, bus_busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        acc = '0;
        for (int s = 0; s < 6; s++) begin
            @(negedge clock);
            acc = acc | bus_data | {28'd0, bus_valid, bus_end, bus_err, bus_busy};
        end
        check("post-reset silent", acc, 32'd0);

        run_row(mk(1, 32'h5000_0010, 8'd1, 4'hF, 2, 32'hDEAD0001, 32'd2, 0, 0, 0, 0, 2), 100);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
